digit_scan_ctrl: RTL and testbench
==================================

# digit_scan_ctrl

Sequential scan controller that sits directly upstream of the 2-to-4 decoder. It steps a registered 2-bit select through positions 0..3 and drives the decoder's `a` (MSB) and `b` (LSB) inputs. Each position is preceded by a blanking gap, so the decoder output is never enabled while the select changes. The controller supports start, a hold that freezes the current position, and a stop that completes the current frame before going idle.

## Interface

Parameters:
- `DIV`, default 8: dwell cycles per position with `dec_en`=1. Legal range ≥2.
- `BLANK`, default 2: blank cycles before each position with `dec_en`=0. Legal range ≥1.

Ports:
- `clk`, input, 1 bit: the single clock. All state updates on the rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `start`, input, 1 bit: begin scanning. Sampled only in IDLE.
- `stop`, input, 1 bit: request to end after the current frame. Sticky until honoured.
- `hold`, input, 1 bit: level-sensitive. Freezes the dwell count while showing.
- `sel_a`, output, 1 bit: select MSB. Connects to decoder `a`.
- `sel_b`, output, 1 bit: select LSB. Connects to decoder `b`.
- `dec_en`, output, 1 bit: qualifies decoder outputs. Asserted only in SHOW and HOLD.
- `frame_done`, output, 1 bit: one-cycle pulse when position 3's dwell completes.
- `busy`, output, 1 bit: high whenever the state is not IDLE.

## Operation

- Reset values: state IDLE, {`sel_a`,`sel_b`}=00, `dec_en`=0, `frame_done`=0, `busy`=0, counters 0, stop latch 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- State machine: IDLE, BLANK, SHOW, HOLD.
  - IDLE + `start`=1 → BLANK. Select loads 00, counter clears, `busy`=1.
  - BLANK: counts BLANK cycles with `dec_en`=0, then → SHOW. `hold` is ignored in BLANK.
  - SHOW: counts DIV cycles with `dec_en`=1.
    - `hold`=1 → HOLD. The counter value is retained.
    - At the dwell end with select<3: select increments, → BLANK.
    - At the dwell end with select=3: `frame_done` pulses. If the stop latch is set → IDLE, select=00, latch cleared. Otherwise select wraps to 00, → BLANK.
  - HOLD: `dec_en` stays 1, and the select and counter are frozen. When `hold`=0 → SHOW and the count resumes from the retained value.
- The select changes only on the transition into BLANK (or on the return to IDLE). It never changes while `dec_en`=1.
- `stop` sets the latch in any non-IDLE state, including HOLD and BLANK.
- Boundary and simultaneous-event rules:
  - `stop` in IDLE is ignored.
  - `start` outside IDLE is ignored.
  - `start` and `stop` in the same IDLE cycle: the scan starts, runs exactly one frame, then returns to IDLE.
  - `stop` asserted on the same cycle as the final dwell cycle of position 3 is honoured in that same frame.
  - `hold` asserted on the final dwell cycle: HOLD takes priority and the dwell end is deferred until release.
  - `rst_n` low mid-frame: all outputs return to their reset values immediately (asynchronously), with no `frame_done` pulse.
- Width rules:
  - Dwell counter width is $clog2(DIV). Blank counter width is $clog2(BLANK+1).
  - The select is 2 bits and wraps modulo 4.

## Timing

- `start` sampled at edge E0: `busy`=1 and BLANK begin after E0.
- `dec_en` first rises after edge E0+BLANK.
- Per position: BLANK cycles of `dec_en`=0, then DIV cycles of `dec_en`=1.
- Frame length with no hold: 4×(BLANK+DIV) cycles. With defaults this is 40 cycles.
- `frame_done` is high for the one cycle immediately following the last `dec_en`=1 cycle of position 3. In that same cycle `dec_en`=0 and the select is already 00.
- Each HOLD cycle extends the frame by exactly one cycle.

## Structure

- Shared package `scan_pkg` holds:
  - the state enum (IDLE, BLANK, SHOW, HOLD);
  - the 2-bit select typedef;
  - the constant LAST_SEL=2'd3.
- One sub-module, `scan_timer`: a loadable down-counter with freeze and `done` outputs. It is instantiated twice, once for the dwell interval and once for the blank interval.
- The top level contains the FSM, the select register, the stop latch and the output registers.

## Test plan

All scenarios use defaults (DIV=8, BLANK=2) unless stated.

1. Reset, then pulse `start` → select sequence 00, 01, 10, 11, 00. Each position shows 2 cycles `dec_en`=0 followed by 8 cycles `dec_en`=1. `frame_done` pulses every 40 cycles.
2. Assert `hold` for 5 cycles during position 01's dwell → `dec_en` stays 1, the select stays 01, and that frame lasts 45 cycles.
3. Pulse `stop` mid-position 10 → the scan completes positions 10 and 11, `frame_done` pulses once, then `busy`=0 and the select is 00.
4. `start` and `stop` in the same IDLE cycle → exactly one 40-cycle frame, then IDLE.
5. Drop `rst_n` during position 11 with `dec_en`=1 → all outputs 0 immediately. After reset release the block stays IDLE until `start`.
6. Every cycle of every run, checked against the decoder model → the select never changes while `dec_en`=1, and exactly one decoder output is active whenever `dec_en`=1.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the digit scan controller and its timers.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2,
        ST_HOLD  = 2'd3
    } scan_state_e;

    typedef logic [1:0] sel_t;

    localparam sel_t LAST_SEL = 2'd3;

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter that saturates at zero; done flags the final counted cycle.
module scan_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         freeze,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (!freeze && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Scan controller stepping a 2-bit decoder select through 0..3, with a blanking
// gap before every position, hold-to-freeze and stop-at-end-of-frame.
// Handshake: start/stop/hold are plain levels sampled every rising edge; there is
// no ready path, start is simply ignored while busy and stop is latched until honoured.
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int DIV   = 8,
    parameter int BLANK = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        hold,
    output logic        sel_a,
    output logic        sel_b,
    output logic        dec_en,
    output logic        frame_done,
    output logic        busy,
    output scan_state_e state_dbg
);

    localparam int DW = $clog2(DIV);
    localparam int BW = $clog2(BLANK + 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DIV - 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK - 1);

    scan_state_e   state, state_nxt;
    sel_t          sel, sel_nxt;
    logic          stop_latch, stop_nxt;
    logic          fd_nxt;
    logic          blank_load, blank_done;
    logic          dwell_load, dwell_freeze, dwell_done;
    logic [DW-1:0] dwell_val;

    scan_timer #(.W(BW)) u_blank_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (blank_load),
        .value  (BLANK_LOAD),
        .freeze (state != ST_BLANK),
        .done   (blank_done)
    );

    scan_timer #(.W(DW)) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (dwell_load),
        .value  (dwell_val),
        .freeze (dwell_freeze),
        .done   (dwell_done)
    );

    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        stop_nxt     = stop_latch;
        fd_nxt       = 1'b0;
        blank_load   = 1'b0;
        dwell_load   = 1'b0;
        dwell_val    = DWELL_LOAD;
        dwell_freeze = 1'b1;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt  = ST_BLANK;
                    sel_nxt    = '0;
                    blank_load = 1'b1;
                    dwell_load = 1'b1;
                    dwell_val  = '0;
                    stop_nxt   = stop;
                end
            end
            ST_BLANK: begin
                if (stop) stop_nxt = 1'b1;
                if (blank_done) begin
                    state_nxt  = ST_SHOW;
                    dwell_load = 1'b1;
                end
            end
            default: begin
                // SHOW and HOLD share one path: the release cycle of a hold
                // counts as a dwell cycle, so each held cycle costs exactly one.
                if (stop) stop_nxt = 1'b1;
                if (hold) begin
                    state_nxt = ST_HOLD;
                end else if (dwell_done) begin
                    sel_nxt = sel + 2'd1;
                    if (sel == LAST_SEL) begin
                        fd_nxt = 1'b1;
                        if (stop_latch || stop) begin
                            state_nxt = ST_IDLE;
                            stop_nxt  = 1'b0;
                        end else begin
                            state_nxt  = ST_BLANK;
                            blank_load = 1'b1;
                        end
                    end else begin
                        state_nxt  = ST_BLANK;
                        blank_load = 1'b1;
                    end
                end else begin
                    state_nxt    = ST_SHOW;
                    dwell_freeze = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sel        <= '0;
            stop_latch <= 1'b0;
            dec_en     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            stop_latch <= stop_nxt;
            dec_en     <= (state_nxt == ST_SHOW) || (state_nxt == ST_HOLD);
            frame_done <= fd_nxt;
            busy       <= (state_nxt != ST_IDLE);
        end
    end

    assign sel_a     = sel[1];
    assign sel_b     = sel[0];
    assign state_dbg = state;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: randomized directed steps checked every cycle against
// a frame-progress model (position and phase derived from a cycle index within the frame).
module tb_digit_scan_ctrl;
    import scan_pkg::*;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int P     = DIV + BLANK;
    localparam int FRAME = 4 * P;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic hold = 1'b0;
    logic sel_a, sel_b, dec_en, frame_done, busy;
    scan_state_e state_dbg;

    always #5 clk = ~clk;

    digit_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .hold       (hold),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .dec_en     (dec_en),
        .frame_done (frame_done),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // scoreboard
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [4:0] exp_q[$];
    int fd_cnt = 0;
    int last_fd_cyc = 0;
    int fd_gap = 0;
    logic prev_dec_en = 1'b0;
    logic [1:0] prev_sel = 2'b00;

    // reference model: m_t is the cycle index within the frame, advanced except
    // while a showing cycle is held
    bit   m_active = 1'b0;
    bit   m_stop = 1'b0;
    int   m_t = 0;
    logic m_fd = 1'b0;

    function automatic logic [4:0] model_out();
        logic [1:0] s;
        logic d;
        s = m_active ? 2'(m_t / P) : 2'b00;
        d = m_active && ((m_t % P) >= BLANK);
        return {s, d, m_fd, logic'(m_active)};
    endfunction

    task automatic model_step(input logic s, input logic p, input logic h);
        m_fd = 1'b0;
        if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_t = 0;
                m_stop = p;
            end
        end else begin
            m_stop = m_stop | p;
            if (!(((m_t % P) >= BLANK) && h)) begin
                if (m_t == FRAME - 1) begin
                    m_fd = 1'b1;
                    m_t = 0;
                    if (m_stop) begin
                        m_active = 1'b0;
                        m_stop = 1'b0;
                    end
                end else begin
                    m_t++;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_stop = 1'b0;
        m_t = 0;
        m_fd = 1'b0;
        prev_dec_en = 1'b0;
    endtask

    task automatic check_outputs();
        logic [4:0] exp;
        logic [4:0] obs;
        logic [3:0] dec;
        exp = exp_q.pop_front();
        obs = {sel_a, sel_b, dec_en, frame_done, busy};
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL outputs cyc=%0d observed sel,en,fd,busy=%b expected=%b", cyc, obs, exp);
        end
        if (dec_en === 1'b1) begin
            dec = 4'b0001 << {sel_a, sel_b};
            n_cmp++;
            assert ($countones(dec) == 1) else begin
                n_fail++;
                $error("FAIL decoder_onehot cyc=%0d observed=%b expected one hot", cyc, dec);
            end
            if (prev_dec_en) begin
                n_cmp++;
                assert ({sel_a, sel_b} === prev_sel) else begin
                    n_fail++;
                    $error("FAIL sel_stable cyc=%0d observed=%b expected=%b", cyc, {sel_a, sel_b}, prev_sel);
                end
            end
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_gap = cyc - last_fd_cyc;
            last_fd_cyc = cyc;
        end
        prev_dec_en = (dec_en === 1'b1);
        prev_sel = {sel_a, sel_b};
    endtask

    // drivers
    task automatic cycle(input logic s, input logic p, input logic h);
        start = s;
        stop = p;
        hold = h;
        @(posedge clk);
        cyc++;
        model_step(s, p, h);
        exp_q.push_back(model_out());
        #1;
        check_outputs();
    endtask

    function automatic logic coin(input int n);
        return ($urandom_range(0, n - 1) == 0);
    endfunction

    task automatic run_until_t(input int target);
        int n = 0;
        while (!(m_active && m_t == target) && n < 200) begin
            cycle(coin(2), 1'b0, 1'b0);
            n++;
        end
        n_cmp++;
        assert (m_active && m_t == target) else begin
            n_fail++;
            $error("FAIL reach_position observed t=%0d expected t=%0d within 200 cycles", m_t, target);
        end
    endtask

    task automatic run_until_idle(input int bound, input bit rand_hold);
        int n = 0;
        while (m_active && n < bound) begin
            cycle(coin(2), 1'b0, rand_hold ? coin(4) : 1'b0);
            n++;
        end
    endtask

    task automatic check_value(input string tag, input int observed, input int expected);
        n_cmp++;
        assert (observed == expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        int snap;

        // reset state
        #2;
        exp_q.push_back(5'b0);
        check_outputs();
        #10;
        rst_n = 1'b1;

        // stop in IDLE is ignored
        for (int i = 0; i < 4; i++) cycle(1'b0, coin(2), coin(2));

        // free-running scan: two frames of exactly FRAME cycles
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2 * FRAME; i++) cycle(coin(2), 1'b0, 1'b0);
        check_value("frame_len", fd_gap, FRAME);

        // hold for 5 cycles during position 01's dwell
        run_until_t(P + BLANK + 2);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
        run_until_t(0);
        check_value("frame_len_hold", fd_gap, FRAME + 5);

        // random holds for a while
        for (int i = 0; i < FRAME + 30; i++) cycle(coin(2), 1'b0, coin(4));

        // stop in the middle of position 10
        run_until_t(2 * P + 5);
        snap = fd_cnt;
        cycle(1'b0, 1'b1, coin(2));
        run_until_idle(200, 1'b1);
        check_value("stop_frame_done_count", fd_cnt, snap + 1);
        check_value("stop_busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, coin(2), 1'b0);

        // start and stop together: one frame then idle
        snap = fd_cnt;
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < FRAME - 1; i++) cycle(coin(2), 1'b0, 1'b0);
        check_value("one_frame_busy_before_end", int'(busy), 1);
        cycle(1'b0, 1'b0, 1'b0);
        check_value("one_frame_done", fd_cnt, snap + 1);
        check_value("one_frame_idle", int'(busy), 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);

        // stop and hold on the final dwell cycle of position 11
        cycle(1'b1, 1'b0, 1'b0);
        run_until_t(FRAME - 1);
        snap = fd_cnt;
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check_value("hold_defers_done", fd_cnt, snap);
        cycle(1'b0, 1'b0, 1'b0);
        check_value("final_stop_done", fd_cnt, snap + 1);
        check_value("final_stop_idle", int'(busy), 0);
        cycle(1'b0, 1'b0, 1'b0);

        // asynchronous reset while position 11 is showing
        cycle(1'b1, 1'b0, 1'b0);
        run_until_t(3 * P + BLANK + 3);
        snap = fd_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(5'b0);
        check_outputs();
        @(posedge clk);
        #1;
        exp_q.push_back(5'b0);
        check_outputs();
        check_value("reset_no_frame_done", fd_cnt, snap);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b0, coin(2), coin(2));

        // restart after reset with random stimulus
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < FRAME + 20; i++) cycle(coin(2), coin(16), coin(4));
        run_until_idle(300, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
